// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register-file block.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } i2c_state_e;

  localparam logic [6:0] I2C_GENCALL_ADDR = 7'h00;
  localparam logic [7:0] GENCALL_RESET    = 8'h06;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchroniser plus glitch filter for one open-drain bus line.
// The filtered level moves only after FILT_LEN consecutive differing samples; rise/fall pulse with it.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILT_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= CNT_LOAD;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= CNT_LOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing register pointer and a byte-wide register-bank port.
// Build option I2C_GENERAL_CALL_EN: ACK general-call address 0x00 and its pointer-reset command 0x06.
//
// state       | meaning
// S_IDLE      | bus free, waiting for START
// S_ADDR      | shifting in address + R/W
// S_ADDR_ACK  | driving ACK for a matched address
// S_PTR       | shifting in register pointer (or general-call command)
// S_PTR_ACK   | driving ACK for the pointer byte
// S_WDATA     | shifting in a write data byte
// S_WDATA_ACK | driving ACK for write data, pointer advances after it
// S_RDATA     | driving a read data byte MSB first
// S_RDATA_ACK | released SDA, sampling controller ACK/NACK
// S_IGNORE    | not addressed or transfer aborted, wait for START/STOP
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h5A,
  parameter int         NUM_REGS    = 16,
  parameter int         PTR_W       = 4,
  parameter int         FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  input  logic [7:0]       reg_rdata,
  output logic             reg_re,
  output logic             busy
);

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REGS - 1);

  logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .raw(scl_in), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .raw(sda_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  i2c_state_e       state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shifter, shifter_nxt, byte_in, wdata_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, ptr_inc;
  logic             sda_oe_nxt, busy_nxt, we_nxt, re_int;
  logic             rw, rw_nxt, gc, gc_nxt, acked, acked_nxt;

  assign byte_in  = {shifter[6:0], sda};
  assign ptr_inc  = (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
  assign reg_addr = ptr;
  assign reg_re   = re_int & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shifter   <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      rw        <= RW_WRITE;
      gc        <= 1'b0;
      acked     <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shifter   <= shifter_nxt;
      ptr       <= ptr_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      reg_we    <= we_nxt;
      reg_wdata <= wdata_nxt;
      rw        <= rw_nxt;
      gc        <= gc_nxt;
      acked     <= acked_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shifter_nxt = shifter;
    ptr_nxt     = ptr;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    we_nxt      = 1'b0;
    wdata_nxt   = reg_wdata;
    rw_nxt      = rw;
    gc_nxt      = gc;
    acked_nxt   = acked;
    re_int      = 1'b0;
    if (stop_det) begin
      state_nxt  = S_IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt   = S_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_ADDR:
          if (scl_rise) begin
            shifter_nxt = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw_nxt = byte_in[0];
              gc_nxt = 1'b0;
              if (byte_in[7:1] == TARGET_ADDR) begin
                state_nxt = S_ADDR_ACK;
                busy_nxt  = 1'b1;
              end else if (GC_EN && byte_in == {I2C_GENCALL_ADDR, RW_WRITE}) begin
                state_nxt = S_ADDR_ACK;
                gc_nxt    = 1'b1;
                busy_nxt  = 1'b0;
              end else begin
                state_nxt = S_IGNORE;
                busy_nxt  = 1'b0;
              end
            end
          end
        S_ADDR_ACK:
          if (scl_fall) begin
            sda_oe_nxt = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_nxt = '0;
            if (rw == RW_READ) begin
              re_int      = 1'b1;
              shifter_nxt = reg_rdata;
              state_nxt   = S_RDATA;
            end else begin
              state_nxt = S_PTR;
            end
          end
        S_PTR:
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
          end else if (scl_rise) begin
            shifter_nxt = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt = S_IGNORE;
              if (gc) begin
                if (byte_in == GENCALL_RESET) begin
                  ptr_nxt   = '0;
                  state_nxt = S_PTR_ACK;
                end
              end else if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                ptr_nxt   = byte_in[PTR_W-1:0];
                state_nxt = S_PTR_ACK;
              end
            end
          end
        S_PTR_ACK, S_WDATA_ACK:
          if (scl_fall) begin
            sda_oe_nxt = 1'b1;
          end else if (scl_rise) begin
            bit_cnt_nxt = '0;
            // a general-call command ends the transfer once acknowledged
            state_nxt   = (state == S_PTR_ACK && gc) ? S_IGNORE : S_WDATA;
            if (state == S_WDATA_ACK) ptr_nxt = ptr_inc;
          end
        S_WDATA:
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
          end else if (scl_rise) begin
            shifter_nxt = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              we_nxt    = 1'b1;
              wdata_nxt = byte_in;
              state_nxt = S_WDATA_ACK;
            end
          end
        S_RDATA:
          if (scl_fall) begin
            sda_oe_nxt  = ~shifter[7];
            shifter_nxt = {shifter[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nxt = S_RDATA_ACK;
              acked_nxt = 1'b0;
            end
          end
        S_RDATA_ACK:
          if (scl_fall) begin
            if (acked) begin
              // fetch the next byte and put its MSB on the bus in the same cycle
              re_int      = 1'b1;
              shifter_nxt = {reg_rdata[6:0], 1'b0};
              sda_oe_nxt  = ~reg_rdata[7];
              bit_cnt_nxt = '0;
              state_nxt   = S_RDATA;
            end else begin
              sda_oe_nxt = 1'b0;
            end
          end else if (scl_rise) begin
            if (!sda) begin
              acked_nxt = 1'b1;
              ptr_nxt   = ptr_inc;
            end else begin
              state_nxt = S_IGNORE;
            end
          end
        S_IGNORE:
          if (scl_fall) sda_oe_nxt = 1'b0;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboard bench for i2c_target_regfile: a bit-banged controller drives the bus,
// expectations are queued ahead of each transfer and a monitor checks DUT outputs as they appear.
module tb_i2c_target_regfile;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_bus;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [8:0]  exp_bus[$];
  logic [8:0]  act_bus[$];

  always #5 clk = ~clk;

  assign sda_bus   = sda_drv & ~sda_oe;
  assign reg_rdata = 8'(reg_addr);

  i2c_target_regfile dut (
    .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_bus), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .reg_re(reg_re), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [11:0] ew;
    logic [3:0]  er;
    logic [8:0]  ab;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (reg_we) begin
      if (exp_wr.size() == 0) unexpected("reg_we", {reg_addr, reg_wdata});
      else begin
        ew = exp_wr.pop_front();
        check("reg_we", {reg_addr, reg_wdata}, ew);
      end
    end
    if (reg_re) begin
      if (exp_rd.size() == 0) unexpected("reg_re", reg_addr);
      else begin
        er = exp_rd.pop_front();
        check("reg_re", reg_addr, er);
      end
    end
    while (act_bus.size() > 0) begin
      ab = act_bus.pop_front();
      if (exp_bus.size() == 0) unexpected("bus", ab);
      else check("bus", ab, exp_bus.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbit(input logic b, input bit glitch);
    tick(Q); sda_drv = b;
    tick(Q); scl_drv = 1'b1;
    if (glitch) begin
      tick(Q); sda_drv = ~b;
      tick(1); sda_drv = b;
      tick(Q - 1);
    end else begin
      tick(2 * Q);
    end
    scl_drv = 1'b0;
  endtask

  task automatic rbit(output logic b);
    tick(Q); sda_drv = 1'b1;
    tick(Q); scl_drv = 1'b1;
    tick(Q); b = sda_bus;
    tick(Q); scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    tick(Q); sda_drv = 1'b1;
    tick(Q); scl_drv = 1'b1;
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl_drv = 1'b1;
    tick(Q); sda_drv = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(b[i], glitch);
    rbit(a);
    act_bus.push_back({1'b0, 7'd0, a});
  endtask

  task automatic read_byte(input logic ack_bit);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    act_bus.push_back({1'b1, d});
    wbit(ack_bit, 1'b0);
  endtask

  task automatic exp_ack(input logic a);
    exp_bus.push_back({1'b0, 7'd0, a});
  endtask

  task automatic exp_data(input logic [7:0] d);
    exp_bus.push_back({1'b1, d});
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe0, busy0;
    tick(5);
    rst = 1'b0;
    tick(1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_strobes", {reg_we, reg_re}, 0);
    tick(20);

    // multi-byte write from pointer 3
    i2c_start();
    exp_ack(0); write_byte(8'hB4, 0);
    check("busy_addressed", busy, 1);
    exp_ack(0); write_byte(8'h03, 0);
    exp_wr.push_back({4'h3, 8'h11}); exp_ack(0); write_byte(8'h11, 0);
    exp_wr.push_back({4'h4, 8'h22}); exp_ack(0); write_byte(8'h22, 0);
    i2c_stop();
    tick(Q);
    check("busy_after_stop", busy, 0);

    // pointer 0x0F, repeated START, 3-byte read wrapping to 0
    i2c_start();
    exp_ack(0); write_byte(8'hB4, 0);
    exp_ack(0); write_byte(8'h0F, 0);
    i2c_start();
    exp_rd.push_back(4'hF); exp_ack(0); write_byte(8'hB5, 0);
    exp_rd.push_back(4'h0); exp_data(8'h0F); read_byte(0);
    exp_rd.push_back(4'h1); exp_data(8'h00); read_byte(0);
    exp_data(8'h01); read_byte(1);
    tick(Q);
    check("sda_released_after_nack", sda_oe, 0);
    i2c_stop();
    tick(Q);

    // address mismatch: nothing driven, no strobes, never busy
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    exp_ack(1); write_byte(8'hB6, 0);
    exp_ack(1); write_byte(8'h05, 0);
    i2c_stop();
    tick(Q);
    check("mismatch_sda_oe_cycles", oe_cnt - oe0, 0);
    check("mismatch_busy_cycles", busy_cnt - busy0, 0);

    // out-of-range pointer is NACKed and the following data ignored
    i2c_start();
    exp_ack(0); write_byte(8'hB4, 0);
    exp_ack(1); write_byte(8'h20, 0);
    exp_ack(1); write_byte(8'h55, 0);
    i2c_stop();
    tick(Q);

    // 1-clk SDA glitches during SCL high must not look like START/STOP
    i2c_start();
    exp_ack(0); write_byte(8'hB4, 0);
    exp_ack(0); write_byte(8'h05, 0);
    exp_wr.push_back({4'h5, 8'h77}); exp_ack(0); write_byte(8'h77, 1);
    check("busy_after_glitch", busy, 1);
    i2c_stop();
    tick(Q);

    // reset while driving read data (pointer 6 -> 0x06, MSB 0 pulls SDA)
    i2c_start();
    exp_rd.push_back(4'h6); exp_ack(0); write_byte(8'hB5, 0);
    tick(Q);
    check("rdata_driving", sda_oe, 1);
    rst = 1'b1;
    tick(1);
    check("reset_release_sda", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_ptr", reg_addr, 0);
    rst = 1'b0;
    tick(20);
    i2c_stop();
    i2c_start();
    exp_ack(0); write_byte(8'hB4, 0);
    exp_ack(0); write_byte(8'h09, 0);
    exp_wr.push_back({4'h9, 8'hA5}); exp_ack(0); write_byte(8'hA5, 0);
    i2c_stop();
    tick(50);

    check("exp_wr_left", exp_wr.size(), 0);
    check("exp_rd_left", exp_rd.size(), 0);
    check("exp_bus_left", exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
Next-generation I2C target (slave) for the I2C module, with a parametrised address and register-pointer depth.
- Runs entirely on the system clock; SCL and SDA are oversampled, not used as clocks.
- Supports multi-byte write and read with an auto-incrementing register pointer, repeated START, and NACK of unmatched addresses.
- Exposes a simple register-bank port toward the host logic.

Parameters:
- TARGET_ADDR, 7'h5A: 7-bit bus address this target answers to.
- NUM_REGS, 16: number of addressable byte registers (2..256).
- PTR_W, 4: register pointer width; must equal clog2(NUM_REGS).
- FILT_LEN, 3: stable samples required before a filtered SCL/SDA level changes (1..7).

Ports:
- clk, in, 1: system clock; at least 16x SCL rate.
- rst, in, 1: synchronous, active-high reset.
- scl_in, in, 1: raw bus SCL.
- sda_in, in, 1: raw bus SDA.
- sda_oe, out, 1: 1 = pull SDA low (open-drain); 0 = release.
- reg_addr, out, PTR_W: current register pointer.
- reg_wdata, out, 8: write data.
- reg_we, out, 1: one-cycle write strobe.
- reg_rdata, in, 8: combinational read data for reg_addr.
- reg_re, out, 1: one-cycle strobe; reg_rdata is sampled in the same cycle.
- busy, out, 1: high from an addressed START until STOP.

Behaviour:
Input conditioning
- Each input: 2-FF synchroniser, then glitch filter. A filtered level changes only after FILT_LEN consecutive equal samples.
- Edge detection runs on the filtered signals.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are detected in every state.

Bit timing
- Bits are sampled on the filtered SCL rise, MSB first.
- sda_oe changes only on the cycle after a filtered SCL fall.
- Data-path latency from raw input to filtered edge: 2+FILT_LEN clk.

States
- IDLE: wait for START.
- ADDR: shift 8 bits.
  - Match: go to ADDR_ACK, pull low for the 9th clock.
  - Mismatch: go to IGNORE, sda_oe stays 0.
- ADDR_ACK
  - R/W=0: go to PTR.
  - R/W=1: pulse reg_re, load shifter with reg_rdata, go to RDATA.
- PTR: 8 bits.
  - Value < NUM_REGS: load pointer, ACK, go to WDATA.
  - Otherwise: NACK (release), go to IGNORE.
- WDATA: 8 bits.
  - On 8th SCL rise: reg_wdata=byte, reg_we=1 for one clk at reg_addr.
  - ACK, then pointer+1, go to WDATA.
- RDATA: drive bit n = shifter[7-n] (0 → sda_oe=1, 1 → sda_oe=0). After 8 bits release SDA and go to RDATA_ACK.
- RDATA_ACK: sample the controller's bit on the 9th SCL rise.
  - 0 (ACK): pointer+1, reg_re pulse on the following SCL fall, reload, go to RDATA.
  - 1 (NACK): go to IGNORE.
- IGNORE: sda_oe=0; wait for START/STOP.

Pointer
- Wraps NUM_REGS-1 → 0 during both read and write.
- Not cleared by STOP; persists until reset or the next PTR byte. This allows write-pointer, repeated-START, read sequences.

Bus events
- Repeated START in any state: go to ADDR and release SDA on the same cycle it is detected.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- START and STOP never coincide, since both require a distinct SDA edge.

Reset
- Reset values: sda_oe=0, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0, state=IDLE, filters preloaded to 1.
- Reset mid-transfer releases SDA on the next clk.

busy
- Set on ADDR_ACK with a match; cleared on STOP or mismatch.

Optional Feature:
- Macro: I2C_GENERAL_CALL_EN.
- Defined: address byte 8'h00 is ACKed. The following byte 8'h06 resets the pointer to 0, ACKed. Any other following byte is NACKed and the FSM goes to IGNORE. busy stays 0.
- Undefined: 8'h00 is treated as a non-matching address.

Decomposition:
- Package i2c_pkg holds:
  - state enum;
  - I2C_GENCALL_ADDR=7'h00 and GENCALL_RESET=8'h06;
  - direction constants RW_WRITE=0, RW_READ=1.
- Sub-module i2c_in_filter (sync + glitch filter + rise/fall outputs, parameter FILT_LEN) is instantiated twice, once for SCL and once for SDA.

Test Plan:
- Write 0xB4, ptr 0x03, data 0x11,0x22, STOP → ACK on every byte; reg_we at addr 3=0x11 and addr 4=0x22; busy drops after STOP.
- Write ptr 0x0F, repeated START, read 0xB5, 3 bytes with ACK,ACK,NACK (reg file holds value=addr) → SDA carries 0x0F,0x00,0x01 (wrap); SDA released after NACK.
- Address 0xB6 (mismatch) → sda_oe never 1; reg_we/reg_re never pulse; busy stays 0.
- Write ptr 0x20 with NUM_REGS=16 → 9th bit NACK; a following data byte produces no reg_we.
- 1-clk glitch on SDA while SCL high, FILT_LEN=3 → no START/STOP detected; state unchanged.
- Assert rst during RDATA while sda_oe=1 → sda_oe=0 next clk; state IDLE; a subsequent normal write succeeds.
